// File: rtl/axi4lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4lite_pkg
// Shared definitions for the AXI4-Lite master controller:
//   - state_t       : controller FSM states
//   - RESP_*        : AXI response codes carried on BRESP/RRESP
//   - PROT_*        : bit positions inside AxPROT / cmd_prot
// -----------------------------------------------------------------------------
package axi4lite_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_BRESP = 3'd2,
      ST_READ  = 3'd3,
      ST_RDATA = 3'd4,
      ST_RESP  = 3'd5
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int PROT_PRIV   = 0;
   localparam int PROT_NONSEC = 1;
   localparam int PROT_INSTR  = 2;

endpackage

// File: rtl/axi4lite_master_ctrl.sv
// -----------------------------------------------------------------------------
// axi4lite_master_ctrl
// Turns single commands into one AXI4-Lite read or write transaction at a time
// and returns the slave's response on a simple valid/ready response port.
//
// Ports
//   ACLK, ARESETn            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake
//   cmd_write                : 1 = write, 0 = read
//   cmd_addr/wdata/wstrb/prot: command payload, captured on the handshake
//   rsp_valid/rsp_ready      : response handshake
//   rsp_rdata/rsp_resp       : read data (0 for writes) and BRESP/RRESP
//   AW*, W*, B*, AR*, R*     : AXI4-Lite master channels
//
// Every output is a flop. The combinational block computes the value each
// output takes in the next cycle, so no input reaches an output without
// passing through a register.
// -----------------------------------------------------------------------------
module axi4lite_master_ctrl
   import axi4lite_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STRB  = WIDTH / 8
) (
   input  logic             ACLK,
   input  logic             ARESETn,

   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [WIDTH-1:0] cmd_addr,
   input  logic [WIDTH-1:0] cmd_wdata,
   input  logic [STRB-1:0]  cmd_wstrb,
   input  logic [2:0]       cmd_prot,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic [1:0]       rsp_resp,

   output logic             AWVALID,
   output logic [WIDTH-1:0] AWADDR,
   output logic [2:0]       AWPROT,
   input  logic             AWREADY,

   output logic             WVALID,
   output logic [WIDTH-1:0] WDATA,
   output logic [STRB-1:0]  WSTRB,
   input  logic             WREADY,

   input  logic             BVALID,
   input  logic [1:0]       BRESP,
   output logic             BREADY,

   output logic             ARVALID,
   output logic [WIDTH-1:0] ARADDR,
   output logic [2:0]       ARPROT,
   input  logic             ARREADY,

   input  logic             RVALID,
   input  logic [WIDTH-1:0] RDATA,
   input  logic [1:0]       RRESP,
   output logic             RREADY
);

   state_t             state_q, state_d;

   logic               cmd_ready_d;
   logic               rsp_valid_d;
   logic [WIDTH-1:0]   rsp_rdata_d;
   logic [1:0]         rsp_resp_d;
   logic               awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
   logic [WIDTH-1:0]   awaddr_d, wdata_d, araddr_d;
   logic [STRB-1:0]    wstrb_d;
   logic [2:0]         awprot_d, arprot_d;

   // State register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and next output values
   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid;
      rsp_rdata_d = rsp_rdata;
      rsp_resp_d  = rsp_resp;
      awvalid_d   = AWVALID;
      wvalid_d    = WVALID;
      arvalid_d   = ARVALID;
      bready_d    = 1'b0;
      rready_d    = 1'b0;
      awaddr_d    = AWADDR;
      awprot_d    = AWPROT;
      wdata_d     = WDATA;
      wstrb_d     = WSTRB;
      araddr_d    = ARADDR;
      arprot_d    = ARPROT;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               if (cmd_write) begin
                  state_d   = ST_WRITE;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = cmd_addr;
                  awprot_d  = cmd_prot;
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
               end else begin
                  state_d   = ST_READ;
                  arvalid_d = 1'b1;
                  araddr_d  = cmd_addr;
                  arprot_d  = cmd_prot;
               end
            end
         end

         ST_WRITE: begin
            // AW and W retire independently; leave once neither is pending.
            if (AWVALID && AWREADY) awvalid_d = 1'b0;
            if (WVALID && WREADY)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = ST_BRESP;
               bready_d = 1'b1;
            end
         end

         ST_BRESP: begin
            bready_d = 1'b1;
            if (BVALID && BREADY) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_resp_d  = BRESP;
               state_d     = ST_RESP;
            end
         end

         ST_READ: begin
            if (ARVALID && ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RDATA;
            end
         end

         ST_RDATA: begin
            rready_d = 1'b1;
            if (RVALID && RREADY) begin
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = RDATA;
               rsp_resp_d  = RRESP;
               state_d     = ST_RESP;
            end
         end

         ST_RESP: begin
            if (rsp_valid && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
   end

   // Output registers
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= RESP_OKAY;
         AWVALID   <= 1'b0;
         AWADDR    <= '0;
         AWPROT    <= '0;
         WVALID    <= 1'b0;
         WDATA     <= '0;
         WSTRB     <= '0;
         BREADY    <= 1'b0;
         ARVALID   <= 1'b0;
         ARADDR    <= '0;
         ARPROT    <= '0;
         RREADY    <= 1'b0;
      end else begin
         cmd_ready <= cmd_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rsp_rdata_d;
         rsp_resp  <= rsp_resp_d;
         AWVALID   <= awvalid_d;
         AWADDR    <= awaddr_d;
         AWPROT    <= awprot_d;
         WVALID    <= wvalid_d;
         WDATA     <= wdata_d;
         WSTRB     <= wstrb_d;
         BREADY    <= bready_d;
         ARVALID   <= arvalid_d;
         ARADDR    <= araddr_d;
         ARPROT    <= arprot_d;
         RREADY    <= rready_d;
      end
   end

endmodule

// File: tb/tb_axi4lite_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_master_ctrl
// Each transaction is described by its slave timing (ready/valid delays) and
// the expected output waveform is derived as cycle intervals relative to the
// command handshake (cycle 0). Slave inputs outside their meaningful window
// are randomised to exercise ignore/stray behaviour.
// -----------------------------------------------------------------------------
module tb_axi4lite_master_ctrl;
   import axi4lite_pkg::*;

   localparam int W = 32;
   localparam int S = W / 8;

   logic          ACLK, ARESETn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [W-1:0]  cmd_addr, cmd_wdata;
   logic [S-1:0]  cmd_wstrb;
   logic [2:0]    cmd_prot;
   logic          rsp_valid, rsp_ready;
   logic [W-1:0]  rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic          ARVALID, ARREADY, RVALID, RREADY;
   logic [W-1:0]  AWADDR, WDATA, ARADDR, RDATA;
   logic [2:0]    AWPROT, ARPROT;
   logic [S-1:0]  WSTRB;
   logic [1:0]    BRESP, RRESP;

   int n_vec = 0;
   int n_err = 0;

   axi4lite_master_ctrl #(.WIDTH(W), .STRB(S)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp),
      .AWVALID(AWVALID), .AWADDR(AWADDR), .AWPROT(AWPROT), .AWREADY(AWREADY),
      .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
      .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
      .ARVALID(ARVALID), .ARADDR(ARADDR), .ARPROT(ARPROT), .ARREADY(ARREADY),
      .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".cmd_ready"}, cmd_ready, 0);
      chk({tag, ".rsp_valid"}, rsp_valid, 0);
      chk({tag, ".rsp_rdata"}, rsp_rdata, 0);
      chk({tag, ".rsp_resp"},  rsp_resp,  0);
      chk({tag, ".AWVALID"},   AWVALID,   0);
      chk({tag, ".AWADDR"},    AWADDR,    0);
      chk({tag, ".AWPROT"},    AWPROT,    0);
      chk({tag, ".WVALID"},    WVALID,    0);
      chk({tag, ".WDATA"},     WDATA,     0);
      chk({tag, ".WSTRB"},     WSTRB,     0);
      chk({tag, ".BREADY"},    BREADY,    0);
      chk({tag, ".ARVALID"},   ARVALID,   0);
      chk({tag, ".ARADDR"},    ARADDR,    0);
      chk({tag, ".ARPROT"},    ARPROT,    0);
      chk({tag, ".RREADY"},    RREADY,    0);
   endtask

   // One transaction. Slave timing: AW/AR ready after da idle cycles, W ready
   // after dw, B/R valid after db cycles of BREADY/RREADY, rsp_ready after dr
   // cycles of rsp_valid. gap idle cycles precede the command handshake.
   task automatic run_txn(
      input  bit           wr,
      input  logic [W-1:0] addr, data,
      input  logic [S-1:0] strb,
      input  logic [2:0]   prot,
      input  logic [1:0]   resp,
      input  int           da, dw, db, dr, gap, abort_at,
      output int           rise, hold,
      output logic [W-1:0] rdata_seen,
      output logic [1:0]   resp_seen);
      int ta, tw, tb0, tbh, trh;
      ta  = 1 + da;
      tw  = wr ? 1 + dw : 0;
      tb0 = ((tw > ta) ? tw : ta) + 1;
      tbh = tb0 + db;
      trh = tbh + 1 + dr;
      rise = -1; hold = 0; rdata_seen = '0; resp_seen = '0;
      for (int k = -gap; k <= trh; k++) begin
         @(negedge ACLK);
         chk("cmd_ready", cmd_ready, k <= 0);
         chk("AWVALID",   AWVALID,   wr && k >= 1 && k <= ta);
         chk("WVALID",    WVALID,    wr && k >= 1 && k <= tw);
         chk("ARVALID",   ARVALID,   !wr && k >= 1 && k <= ta);
         chk("BREADY",    BREADY,    wr && k >= tb0 && k <= tbh);
         chk("RREADY",    RREADY,    !wr && k >= tb0 && k <= tbh);
         chk("rsp_valid", rsp_valid, k >= tbh + 1 && k <= trh);
         if (wr && k >= 1 && k <= ta) begin
            chk("AWADDR", AWADDR, addr);
            chk("AWPROT", AWPROT, prot);
         end
         if (wr && k >= 1 && k <= tw) begin
            chk("WDATA", WDATA, data);
            chk("WSTRB", WSTRB, strb);
         end
         if (!wr && k >= 1 && k <= ta) begin
            chk("ARADDR", ARADDR, addr);
            chk("ARPROT", ARPROT, prot);
         end
         if (k >= tbh + 1 && k <= trh) begin
            chk("rsp_rdata", rsp_rdata, wr ? '0 : data);
            chk("rsp_resp",  rsp_resp,  resp);
         end
         if (rsp_valid === 1'b1) begin
            hold++;
            if (rise < 0) begin
               rise       = k;
               rdata_seen = rsp_rdata;
               resp_seen  = rsp_resp;
            end
         end
         if (k == abort_at) begin
            ARESETn = 1'b0;
            #1;
            check_all_zero("abort");
            return;
         end
         // drive inputs for this cycle
         cmd_valid = (k == 0) ? 1'b1 : ((k < 0) ? 1'b0 : 1'($urandom % 2));
         cmd_write = (k == 0) ? wr   : 1'($urandom % 2);
         cmd_addr  = (k == 0) ? addr : $urandom;
         cmd_wdata = (k == 0) ? data : $urandom;
         cmd_wstrb = (k == 0) ? strb : S'($urandom);
         cmd_prot  = (k == 0) ? prot : 3'($urandom);
         AWREADY = (wr && k >= 1 && k < ta) ? 1'b0 : ((wr && k == ta) ? 1'b1 : 1'($urandom % 2));
         WREADY  = (wr && k >= 1 && k < tw) ? 1'b0 : ((wr && k == tw) ? 1'b1 : 1'($urandom % 2));
         ARREADY = (!wr && k >= 1 && k < ta) ? 1'b0 : ((!wr && k == ta) ? 1'b1 : 1'($urandom % 2));
         BVALID  = (wr && k >= tb0 && k < tbh) ? 1'b0 : ((wr && k == tbh) ? 1'b1 : 1'($urandom % 2));
         BRESP   = (wr && k == tbh) ? resp : 2'($urandom);
         RVALID  = (!wr && k >= tb0 && k < tbh) ? 1'b0 : ((!wr && k == tbh) ? 1'b1 : 1'($urandom % 2));
         RDATA   = (!wr && k == tbh) ? data : $urandom;
         RRESP   = (!wr && k == tbh) ? resp : 2'($urandom);
         rsp_ready = (k >= tbh + 1 && k < trh) ? 1'b0 : ((k == trh) ? 1'b1 : 1'($urandom % 2));
      end
   endtask

   initial begin
      int rise, hold;
      logic [W-1:0] rd;
      logic [1:0]   rs;
      bit           wr;

      ARESETn = 1'b0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; cmd_prot = 0;
      rsp_ready = 0; AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;

      repeat (3) begin
         @(negedge ACLK);
         check_all_zero("reset");
      end
      ARESETn = 1'b1;
      @(negedge ACLK);
      chk("cmd_ready_after_reset", cmd_ready, 1);

      // all-ready write
      run_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, RESP_OKAY, 0, 0, 0, 0, 0, -100, rise, hold, rd, rs);
      chk("wr_rise", rise, 3);
      chk("wr_rdata", rd, 32'h0);
      chk("wr_resp", rs, 2'b00);

      // all-ready read
      run_txn(0, 32'h20, 32'h12345678, 4'h0, 3'b010, RESP_OKAY, 0, 0, 0, 0, 1, -100, rise, hold, rd, rs);
      chk("rd_rise", rise, 3);
      chk("rd_rdata", rd, 32'h12345678);

      // split write: W first, AW three cycles later; then the reverse order
      run_txn(1, 32'h44, 32'hA5A5_0F0F, 4'h3, 3'b001, RESP_OKAY, 3, 0, 0, 0, 0, -100, rise, hold, rd, rs);
      chk("split_aw_late_rise", rise, 6);
      run_txn(1, 32'h48, 32'h0BAD_F00D, 4'hC, 3'b100, RESP_OKAY, 0, 3, 0, 0, 0, -100, rise, hold, rd, rs);
      chk("split_w_late_rise", rise, 6);

      // SLVERR read under response backpressure
      run_txn(0, 32'h80, 32'hCAFE_0001, 4'h0, 3'b011, RESP_SLVERR, 0, 0, 0, 5, 0, -100, rise, hold, rd, rs);
      chk("slverr_rise", rise, 3);
      chk("slverr_hold", hold, 6);
      chk("slverr_resp", rs, 2'b10);

      // DECERR write with late BVALID
      run_txn(1, 32'hFFFC, 32'h1, 4'h1, 3'b111, RESP_DECERR, 0, 0, 2, 1, 2, -100, rise, hold, rd, rs);
      chk("decerr_rise", rise, 5);
      chk("decerr_resp", rs, 2'b11);

      // reset while waiting in BRESP
      run_txn(1, 32'h100, 32'h5555_AAAA, 4'hF, 3'b000, RESP_OKAY, 0, 0, 4, 0, 0, 4, rise, hold, rd, rs);
      chk("abort_no_rsp", rise, -1);
      cmd_valid = 0; BVALID = 1; BRESP = 2'b11; RVALID = 1;
      repeat (2) begin
         @(negedge ACLK);
         check_all_zero("held_reset");
      end
      ARESETn = 1'b1;
      repeat (3) begin
         @(negedge ACLK);
         chk("stray.cmd_ready", cmd_ready, 1);
         chk("stray.BREADY", BREADY, 0);
         chk("stray.RREADY", RREADY, 0);
         chk("stray.rsp_valid", rsp_valid, 0);
      end
      run_txn(0, 32'h24, 32'h7777_1234, 4'h0, 3'b000, RESP_OKAY, 0, 0, 0, 0, 0, -100, rise, hold, rd, rs);
      chk("post_reset_rise", rise, 3);
      chk("post_reset_rdata", rd, 32'h7777_1234);

      // randomised traffic
      for (int i = 0; i < 150; i++) begin
         wr = 1'($urandom % 2);
         run_txn(wr, $urandom, $urandom, S'($urandom), 3'($urandom), 2'($urandom),
                 $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 4), $urandom_range(0, 2), -100, rise, hold, rd, rs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axi4lite_master_ctrl.md
AXI4LITE_MASTER_CTRL -- requirements
Module: axi4lite_master_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 32, data and address width in bits.
- STRB, WIDTH/8, write-strobe width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. Ports:
- ACLK  in  1  clock, all state on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
REQ-003 Command side SHALL be:
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  WIDTH  byte address.
- cmd_wdata  in  WIDTH  write data.
- cmd_wstrb  in  STRB  byte enables.
- cmd_prot  in  3  {instruction, non-secure, privileged}.
REQ-004 Response side SHALL be:
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
REQ-005 AXI4-Lite master SHALL be:
- AWVALID/AWADDR/AWPROT  out  1/WIDTH/3; AWREADY  in  1.
- WVALID/WDATA/WSTRB  out  1/WIDTH/STRB; WREADY  in  1.
- BVALID  in  1; BRESP  in  2; BREADY  out  1.
- ARVALID/ARADDR/ARPROT  out  1/WIDTH/3; ARREADY  in  1.
- RVALID/RDATA/RRESP  in  1/WIDTH/2; RREADY  out  1.

Function
REQ-006 Every output SHALL be driven from a register; no combinational input-to-output path is permitted.
REQ-007 FSM states SHALL be IDLE, WRITE, BRESP, READ, RDATA and RESP.
REQ-008 cmd_ready SHALL be high only in IDLE; a cmd handshake SHALL capture all cmd_* fields and enter WRITE (cmd_write=1) or READ.
REQ-009 WRITE SHALL assert AWVALID and WVALID together in the first cycle after the cmd handshake.
REQ-010 In WRITE, each VALID SHALL drop in the cycle after its own handshake.
REQ-011 WRITE SHALL move to BRESP once both AW and W handshakes are complete, whether they complete in the same cycle or in different cycles, in either order.
REQ-012 BREADY SHALL be high only in BRESP; the BVALID&BREADY handshake SHALL capture BRESP into rsp_resp, clear rsp_rdata and enter RESP.
REQ-013 READ SHALL assert ARVALID; the ARREADY handshake SHALL enter RDATA.
REQ-014 RREADY SHALL be high only in RDATA; the RVALID&RREADY handshake SHALL capture RDATA and RRESP and enter RESP.
REQ-015 RESP SHALL hold rsp_valid high with stable rsp_* until rsp_ready, then return to IDLE with rsp_valid low.
REQ-016 Once asserted, any VALID SHALL stay high with stable payload until its handshake.
REQ-017 With all slave READY/VALID inputs high, rsp_valid SHALL rise exactly 3 cycles after the cmd handshake for both reads and writes; the next cmd_ready SHALL rise the cycle after the rsp handshake.
REQ-018 At most one transaction SHALL be outstanding; BVALID or RVALID arriving outside BRESP/RDATA SHALL be ignored and leave state unchanged.
REQ-019 SLVERR and DECERR responses SHALL be forwarded unchanged; the block SHALL not retry.

Reset
REQ-020 While ARESETn is low, the FSM SHALL be in IDLE and all VALID/READY outputs, cmd_ready, rsp_valid and all data/addr/resp registers SHALL be 0.
REQ-021 cmd_ready SHALL go to 1 on the first rising edge after ARESETn deasserts.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no response issued.

Structure
REQ-023 A shared package axi4lite_pkg SHALL hold the FSM state enum, the response codes (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and the AxPROT bit positions.
REQ-024 The block SHALL be a single module with no sub-module.

Verification
REQ-025 Write with all slave inputs ready: addr 0x10, data 0xDEADBEEF, strb 0xF, BRESP=00 -> AW/W valid in cycle 1, rsp_valid in cycle 3, rsp_resp=00, rsp_rdata=0.
REQ-026 Read with all slave inputs ready: addr 0x20, RDATA=0x12345678, RRESP=00 -> ARVALID in cycle 1, rsp_valid in cycle 3, rsp_rdata=0x12345678.
REQ-027 Split write: WREADY in cycle 1, AWREADY delayed to cycle 4 -> WVALID low from cycle 2, AWVALID held through cycle 4, BREADY from cycle 5.
REQ-028 Error and backpressure: RRESP=10 with rsp_ready held low for 5 cycles -> rsp_valid and rsp_resp=10 held stable, cmd_ready low until the handshake.
REQ-029 Reset while in BRESP -> all outputs 0 immediately; a later stray BVALID is ignored; a new read completes normally.
